router_fsm: RTL
===============

// Module: router_fsm
// PURPOSE
//  Packet-sequencing controller for the 1x3 router input path.
//  - Decodes the header address and waits for the target output FIFO to drain.
//  - Drives the load/parity strobes of the router register block and the write-enable of the FIFO bank.
//  - Asserts busy toward the source whenever the source must hold its byte.
// PARAMETERS
//  NUM_PORTS  3  number of destination FIFOs; address 0..NUM_PORTS-1 valid
//  ADDR_W     2  width of header address field (data_in[ADDR_W-1:0])
// PORTS
//  clock          in   1          rising-edge system clock
//  reset          in   1          asynchronous, active-high reset
//  pkt_valid      in   1          source byte valid; deasserts on the parity byte
//  data_in        in   ADDR_W     header address bits (data_in[1:0] of the source byte)
//  fifo_full      in   1          full flag of the currently addressed FIFO
//  fifo_empty     in   NUM_PORTS  per-FIFO empty flags
//  soft_reset     in   NUM_PORTS  per-FIFO read-timeout soft reset
//  parity_done    in   1          register block: parity byte captured
//  low_pkt_valid  in   1          register block: pkt_valid fell while FIFO full
//  detect_add     out  1          state == DECODE_ADDRESS
//  lfd_state      out  1          state == LOAD_FIRST_DATA
//  ld_state       out  1          state == LOAD_DATA
//  laf_state      out  1          state == LOAD_AFTER_FULL
//  full_state     out  1          state == FIFO_FULL_STATE
//  rst_int_reg    out  1          state == CHECK_PARITY_ERROR
//  write_enb_reg  out  1          FIFO write enable: LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
//  busy           out  1          high in every state except DECODE_ADDRESS and LOAD_DATA
//  addr_lat       out  ADDR_W     latched destination address
// BEHAVIOUR
//  - Moore FSM; all outputs are decoded from the state register only. No input-to-output combinational path.
//  - Reset (async, any time, including mid-packet):
//    - state = DECODE_ADDRESS and addr_lat = 0.
//    - Outputs: detect_add = 1; every other strobe and busy = 0.
//  - The address is invalid when data_in >= NUM_PORTS (2'b11 at default).
//  - addr_lat loads data_in when state == DECODE_ADDRESS, pkt_valid = 1 and the address is valid. It holds otherwise.
//  - Transitions, one per clock:
//    - DECODE_ADDRESS:
//      - pkt_valid & valid & fifo_empty[data_in] -> LOAD_FIRST_DATA.
//      - pkt_valid & valid & !fifo_empty[data_in] -> WAIT_TILL_EMPTY.
//      - Otherwise (including an invalid address, which drops the packet) stay.
//    - WAIT_TILL_EMPTY: fifo_empty[addr_lat] -> LOAD_FIRST_DATA, else stay.
//    - LOAD_FIRST_DATA: -> LOAD_DATA, unconditionally. The header is written one cycle later.
//    - LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay. fifo_full has priority.
//    - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL, else stay.
//    - LOAD_AFTER_FULL:
//      - parity_done -> DECODE_ADDRESS.
//      - low_pkt_valid -> LOAD_PARITY.
//      - Otherwise -> LOAD_DATA.
//    - LOAD_PARITY: -> CHECK_PARITY_ERROR, unconditionally.
//    - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
//  - Soft reset:
//    - soft_reset[addr_lat] = 1 in any state other than DECODE_ADDRESS -> DECODE_ADDRESS next cycle.
//    - Soft reset overrides all other transitions.
//    - soft_reset on a non-latched port is ignored.
//  - Latency: header accepted in DECODE_ADDRESS -> first FIFO write (LOAD_DATA) is 2 clocks later when the FIFO is empty.
//  - Unused state encodings -> DECODE_ADDRESS on the next clock.
// STRUCTURE
//  - Shared package router_pkg holds:
//    - state encoding localparams (3-bit, 8 states);
//    - NUM_PORTS and ADDR_W defaults;
//    - the ADDR_INVALID constant.
//  - The block is a single module with no sub-module.
//  - It has two always blocks: a state/addr_lat register with async reset, and a combinational next-state block.
//    Output decode is done with continuous assigns.
// TESTING
//  1. Reset held, then released.
//     -> detect_add = 1, busy = 0, write_enb_reg = 0, addr_lat = 0.
//  2. All FIFOs empty; header 8'h05 (addr 1) with pkt_valid, 4 payload bytes, then pkt_valid low.
//     -> States LFD, LD x4, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE_ADDRESS.
//     -> rst_int_reg high for 1 cycle; addr_lat = 1.
//  3. fifo_empty = 3'b011; header for addr 2.
//     -> WAIT_TILL_EMPTY with busy = 1 until fifo_empty[2] rises, then LFD next clock.
//  4. In LOAD_DATA, fifo_full = 1 for 3 cycles.
//     -> FIFO_FULL_STATE for 3 cycles, then LAF.
//     -> With parity_done = 0 and low_pkt_valid = 0, return to LOAD_DATA.
//     -> With low_pkt_valid = 1, go to LOAD_PARITY instead.
//  5. Header with data_in = 2'b11 and pkt_valid.
//     -> Stays in DECODE_ADDRESS; addr_lat unchanged; no write_enb_reg.
//  6. Mid-packet soft_reset[addr_lat] pulse for 1 clock, with an async reset asserted in a later packet.
//     -> DECODE_ADDRESS next clock after the soft reset.
//     -> Async reset forces DECODE_ADDRESS immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router input-path controller.
package router_pkg;

  localparam int unsigned NUM_PORTS_DEF = 3;
  localparam int unsigned ADDR_W_DEF    = 2;

  // Header address that selects no destination FIFO at the default port count.
  localparam logic [ADDR_W_DEF-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

endpackage

// File: rtl/router_fsm.sv
// Packet-sequencing controller: decodes the header, waits for the target FIFO
// and drives the register-block strobes, FIFO write enable and source busy.
module router_fsm
  import router_pkg::*;
#(
  parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic                 busy,
  output logic [ADDR_W-1:0]    addr_lat
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              addr_valid;
  logic              empty_in;
  logic              empty_lat;
  logic              srst_lat;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= DECODE_ADDRESS;
      addr_lat <= '0;
    end else begin
      state    <= state_nxt;
      addr_lat <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt  = DECODE_ADDRESS;
    addr_nxt   = addr_lat;
    empty_in   = 1'b0;
    empty_lat  = 1'b0;
    srst_lat   = 1'b0;
    addr_valid = 32'(data_in) < NUM_PORTS;

    // Port selection by loop keeps out-of-range addresses from indexing past the flags.
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (32'(data_in) == i) empty_in = fifo_empty[i];
      if (32'(addr_lat) == i) begin
        empty_lat = fifo_empty[i];
        srst_lat  = soft_reset[i];
      end
    end

    case (state)
      DECODE_ADDRESS: begin
        if (pkt_valid && addr_valid) begin
          addr_nxt  = data_in;
          state_nxt = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end else begin
          state_nxt = DECODE_ADDRESS;
        end
      end
      WAIT_TILL_EMPTY:    state_nxt = empty_lat ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA:    state_nxt = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_nxt = FIFO_FULL_STATE;
        else if (!pkt_valid) state_nxt = LOAD_PARITY;
        else                 state_nxt = LOAD_DATA;
      end
      FIFO_FULL_STATE:    state_nxt = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_nxt = DECODE_ADDRESS;
        else if (low_pkt_valid) state_nxt = LOAD_PARITY;
        else                    state_nxt = LOAD_DATA;
      end
      LOAD_PARITY:        state_nxt = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:            state_nxt = DECODE_ADDRESS;
    endcase

    if (state != DECODE_ADDRESS && srst_lat) state_nxt = DECODE_ADDRESS;
  end

  assign detect_add    = (state == DECODE_ADDRESS);
  assign lfd_state     = (state == LOAD_FIRST_DATA);
  assign ld_state      = (state == LOAD_DATA);
  assign laf_state     = (state == LOAD_AFTER_FULL);
  assign full_state    = (state == FIFO_FULL_STATE);
  assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
  assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                         (state == LOAD_AFTER_FULL);
  assign busy          = (state != DECODE_ADDRESS) && (state != LOAD_DATA);

endmodule
